// File: rtl/cim_tile_wr_arbiter.sv
// Round-robin arbiter sharing the CIM SRAM write port between two PE tile writers.
// One buffered tile per PE; granted entries become registered single-word writes.
module cim_tile_wr_arbiter #(
    parameter int unsigned TILE_N = 6,
    parameter int unsigned TILE_W = 12,
    parameter int unsigned OD_W   = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              mem_sel_pe,
    input  logic                              cnt_clr,
    input  logic                              req_valid_1,
    output logic                              req_ready_1,
    input  logic [TILE_N*TILE_N*TILE_W-1:0]   req_tile_1,
    input  logic [OD_W-1:0]                   req_od_1,
    input  logic [ADDR_W-1:0]                 req_addr_1,
    input  logic                              req_valid_2,
    output logic                              req_ready_2,
    input  logic [TILE_N*TILE_N*TILE_W-1:0]   req_tile_2,
    input  logic [OD_W-1:0]                   req_od_2,
    input  logic [ADDR_W-1:0]                 req_addr_2,
    output logic                              sram_we,
    output logic [ADDR_W-1:0]                 sram_addr,
    output logic [DATA_W-1:0]                 sram_wdata,
    output logic                              idle,
    output logic [CNT_W-1:0]                  wr_count_1,
    output logic [CNT_W-1:0]                  wr_count_2
);

    localparam int unsigned TILE_BITS = TILE_N * TILE_N * TILE_W;
    localparam int unsigned WORD_BITS = TILE_BITS + OD_W;

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [OD_W-1:0]      od;
        logic [TILE_BITS-1:0] tile;
    } entry_t;

    entry_t ent1_q;
    entry_t ent2_q;
    logic   full1_q;
    logic   full2_q;
    logic   rr_q;        // 0: PE1 favoured on contention, 1: PE2
    logic   grant1_c;
    logic   grant2_c;
    logic   acc1_c;
    logic   acc2_c;

    // Grant selection: only while the PE side owns the SRAM
    always_comb begin
        grant1_c = 1'b0;
        grant2_c = 1'b0;
        if (mem_sel_pe) begin
            if (full1_q && full2_q) begin
                if (rr_q) begin
                    grant2_c = 1'b1;
                end else begin
                    grant1_c = 1'b1;
                end
            end else if (full1_q) begin
                grant1_c = 1'b1;
            end else if (full2_q) begin
                grant2_c = 1'b1;
            end
        end
    end

    // A granted entry frees its slot in the same cycle, so a refill can land at the same edge
    assign req_ready_1 = rst_n & mem_sel_pe & (~full1_q | grant1_c);
    assign req_ready_2 = rst_n & mem_sel_pe & (~full2_q | grant2_c);
    assign acc1_c      = req_valid_1 & req_ready_1;
    assign acc2_c      = req_valid_2 & req_ready_2;
    assign idle        = ~full1_q & ~full2_q & ~sram_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full1_q <= 1'b0;
            full2_q <= 1'b0;
            ent1_q  <= '0;
            ent2_q  <= '0;
        end else begin
            if (acc1_c) begin
                ent1_q  <= '{addr: req_addr_1, od: req_od_1, tile: req_tile_1};
                full1_q <= 1'b1;
            end else if (grant1_c) begin
                full1_q <= 1'b0;
            end
            if (acc2_c) begin
                ent2_q  <= '{addr: req_addr_2, od: req_od_2, tile: req_tile_2};
                full2_q <= 1'b1;
            end else if (grant2_c) begin
                full2_q <= 1'b0;
            end
        end
    end

    // Registered write port and round-robin pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            rr_q       <= 1'b0;
        end else begin
            sram_we <= grant1_c | grant2_c;
            if (grant1_c) begin
                sram_addr  <= ent1_q.addr;
                sram_wdata <= DATA_W'({ent1_q.od, ent1_q.tile});
                rr_q       <= 1'b1;
            end else if (grant2_c) begin
                sram_addr  <= ent2_q.addr;
                sram_wdata <= DATA_W'({ent2_q.od, ent2_q.tile});
                rr_q       <= 1'b0;
            end
        end
    end

    // Per-requester write counters; clear has priority over a same-cycle grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_1 <= '0;
            wr_count_2 <= '0;
        end else if (cnt_clr) begin
            wr_count_1 <= '0;
            wr_count_2 <= '0;
        end else begin
            if (grant1_c) begin
                wr_count_1 <= wr_count_1 + CNT_W'(1);
            end
            if (grant2_c) begin
                wr_count_2 <= wr_count_2 + CNT_W'(1);
            end
        end
    end

    if (DATA_W < WORD_BITS) begin : g_width_check
        $error("DATA_W too narrow for tile plus od index");
    end

endmodule

// File: tb/tb_cim_tile_wr_arbiter.sv
// Directed bench for cim_tile_wr_arbiter: logs every SRAM write and compares it with
// hand-built tile words for each scenario.
module tb_cim_tile_wr_arbiter;

    localparam int unsigned TB = 432;
    localparam int unsigned DW = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_sel_pe;
    logic          cnt_clr;
    logic          req_valid_1, req_valid_2;
    logic          req_ready_1, req_ready_2;
    logic [TB-1:0] req_tile_1, req_tile_2;
    logic [7:0]    req_od_1, req_od_2;
    logic [7:0]    req_addr_1, req_addr_2;
    logic          sram_we;
    logic [7:0]    sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          idle;
    logic [15:0]   wr_count_1, wr_count_2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int            cyc;
        logic [7:0]    addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t wlog[$];

    cim_tile_wr_arbiter dut (
        .clk(clk), .rst_n(rst_n), .mem_sel_pe(mem_sel_pe), .cnt_clr(cnt_clr),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_tile_1(req_tile_1),
        .req_od_1(req_od_1), .req_addr_1(req_addr_1),
        .req_valid_2(req_valid_2), .req_ready_2(req_ready_2), .req_tile_2(req_tile_2),
        .req_od_2(req_od_2), .req_addr_2(req_addr_2),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .idle(idle),
        .wr_count_1(wr_count_1), .wr_count_2(wr_count_2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && sram_we === 1'b1) begin
            wr_t w;
            w.cyc  = cyc;
            w.addr = sram_addr;
            w.data = sram_wdata;
            wlog.push_back(w);
        end
    end

    function automatic logic [TB-1:0] mk_tile(input logic [11:0] v);
        logic [TB-1:0] t;
        for (int i = 0; i < 36; i++) t[i*12 +: 12] = v;
        return t;
    endfunction

    function automatic logic [DW-1:0] mk_word(input logic [11:0] v, input logic [7:0] od);
        logic [DW-1:0] w;
        w = '0;
        w[431:0]   = mk_tile(v);
        w[439:432] = od;
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid_1 = 1'b0; req_valid_2 = 1'b0; cnt_clr = 1'b0; mem_sel_pe = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wlog.delete();
    endtask

    // Present one or two requests; returns at the negedge after the last accept
    task automatic push(input bit v1, input logic [11:0] t1, input logic [7:0] od1,
                        input logic [7:0] a1, input bit v2, input logic [11:0] t2,
                        input logic [7:0] od2, input logic [7:0] a2);
        bit p1, p2, x1, x2;
        int n;
        p1 = v1; p2 = v2; n = 0;
        @(negedge clk);
        req_tile_1 = mk_tile(t1); req_od_1 = od1; req_addr_1 = a1;
        req_tile_2 = mk_tile(t2); req_od_2 = od2; req_addr_2 = a2;
        req_valid_1 = p1; req_valid_2 = p2;
        while ((p1 || p2) && n < 20) begin
            #1;
            x1 = p1 && req_ready_1;
            x2 = p2 && req_ready_2;
            @(negedge clk);
            if (x1) p1 = 1'b0;
            if (x2) p2 = 1'b0;
            req_valid_1 = p1; req_valid_2 = p2;
            n++;
        end
        if (p1 || p2) begin
            n_tests++; n_fail++;
            $display("FAIL push_timeout: pending pe1=%0b pe2=%0b after %0d cycles", p1, p2, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; mem_sel_pe = 1'b1; cnt_clr = 1'b0;
        req_valid_1 = 1'b1; req_valid_2 = 1'b1;
        #1;
        n_tests++;
        if ({sram_we, req_ready_1, req_ready_2, idle} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_ctl: got we/rdy1/rdy2/idle=%b want 0001",
                     {sram_we, req_ready_1, req_ready_2, idle});
        end
        n_tests++;
        if (sram_addr !== 8'd0 || sram_wdata !== '0 || wr_count_1 !== 16'd0 || wr_count_2 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_regs: addr=%0d cnt1=%0d cnt2=%0d want all 0",
                     sram_addr, wr_count_1, wr_count_2);
        end
        req_valid_1 = 1'b0; req_valid_2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wlog.delete();
    endtask

    task automatic test_single();
        do_reset();
        push(1'b1, 12'h0CC, 8'd0, 8'd3, 1'b0, 12'h0, 8'd0, 8'd0);
        repeat (4) @(negedge clk);
        n_tests++;
        if (wlog.size() !== 1) begin
            n_fail++;
            $display("FAIL single_count: got %0d writes want 1", wlog.size());
        end else begin
            n_tests++;
            if (wlog[0].addr !== 8'd3 || wlog[0].data !== mk_word(12'h0CC, 8'd0)) begin
                n_fail++;
                $display("FAIL single_word: addr=%0d data_hi=%h want addr 3", wlog[0].addr, wlog[0].data[511:420]);
            end
        end
        n_tests++;
        if (wr_count_1 !== 16'd1 || wr_count_2 !== 16'd0 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL single_cnt: cnt1=%0d cnt2=%0d idle=%b want 1 0 1", wr_count_1, wr_count_2, idle);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0]    ea[5];
        logic [DW-1:0] ed[5];
        ea = '{8'd3, 8'd4, 8'd7, 8'd6, 8'd5};
        ed = '{mk_word(12'h0CC, 8'd0), mk_word(12'h0DD, 8'd1), mk_word(12'h0EE, 8'd2),
               mk_word(12'h0BB, 8'd4), mk_word(12'h0AA, 8'd3)};
        do_reset();
        push(1'b1, 12'h0CC, 8'd0, 8'd3, 1'b1, 12'h0DD, 8'd1, 8'd4);
        repeat (4) @(negedge clk);
        push(1'b1, 12'h0EE, 8'd2, 8'd7, 1'b0, 12'h0, 8'd0, 8'd0);
        repeat (4) @(negedge clk);
        push(1'b1, 12'h0AA, 8'd3, 8'd5, 1'b1, 12'h0BB, 8'd4, 8'd6);
        repeat (4) @(negedge clk);
        n_tests++;
        if (wlog.size() !== 5) begin
            n_fail++;
            $display("FAIL rr_count: got %0d writes want 5", wlog.size());
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (i >= wlog.size()) begin
                n_fail++;
                $display("FAIL rr_write%0d: missing, want addr %0d", i, ea[i]);
            end else if (wlog[i].addr !== ea[i] || wlog[i].data !== ed[i]) begin
                n_fail++;
                $display("FAIL rr_write%0d: got addr %0d want %0d", i, wlog[i].addr, ea[i]);
            end
        end
        n_tests++;
        if (wlog.size() < 2 || wlog[1].cyc !== wlog[0].cyc + 1) begin
            n_fail++;
            $display("FAIL rr_consecutive: first pair not on consecutive cycles");
        end
        n_tests++;
        if (wr_count_1 !== 16'd3 || wr_count_2 !== 16'd2) begin
            n_fail++;
            $display("FAIL rr_cnt: cnt1=%0d cnt2=%0d want 3 2", wr_count_1, wr_count_2);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            req_valid_1 = 1'b1;
            req_tile_1  = mk_tile(12'(i + 1));
            req_od_1    = 8'd0;
            req_addr_1  = 8'(i);
            #1;
            n_tests++;
            if (req_ready_1 !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready%0d: got %b want 1", i, req_ready_1);
            end
            @(negedge clk);
        end
        req_valid_1 = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (wlog.size() !== 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d writes want 8", wlog.size());
        end
        for (int i = 0; i < 8 && i < wlog.size(); i++) begin
            n_tests++;
            if (wlog[i].addr !== 8'(i) || wlog[i].data !== mk_word(12'(i + 1), 8'd0) ||
                wlog[i].cyc !== wlog[0].cyc + i) begin
                n_fail++;
                $display("FAIL b2b_write%0d: addr=%0d cyc_off=%0d want addr %0d off %0d",
                         i, wlog[i].addr, wlog[i].cyc - wlog[0].cyc, i, i);
            end
        end
    endtask

    task automatic test_scan_hold();
        do_reset();
        push(1'b1, 12'h011, 8'd5, 8'd20, 1'b1, 12'h022, 8'd6, 8'd21);
        mem_sel_pe = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_tests++;
            if ({sram_we, req_ready_1, req_ready_2, idle} !== 4'b0000) begin
                n_fail++;
                $display("FAIL hold_cyc%0d: we/rdy1/rdy2/idle=%b want 0000", i,
                         {sram_we, req_ready_1, req_ready_2, idle});
            end
            @(negedge clk);
        end
        mem_sel_pe = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (wlog.size() !== 2) begin
            n_fail++;
            $display("FAIL hold_count: got %0d writes want 2", wlog.size());
        end else begin
            n_tests++;
            if (wlog[0].addr !== 8'd20 || wlog[0].data !== mk_word(12'h011, 8'd5) ||
                wlog[1].addr !== 8'd21 || wlog[1].data !== mk_word(12'h022, 8'd6)) begin
                n_fail++;
                $display("FAIL hold_data: got addr %0d,%0d want 20,21", wlog[0].addr, wlog[1].addr);
            end
        end
        n_tests++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_idle: got %b want 1", idle);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(1'b1, 12'h0AA, 8'd0, 8'd1, 1'b1, 12'h0BB, 8'd0, 8'd2);
        @(negedge clk);
        n_tests++;
        if (sram_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: sram_we=%b want 1", sram_we);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sram_we, idle, req_ready_1, req_ready_2} !== 4'b0100 ||
            wr_count_1 !== 16'd0 || wr_count_2 !== 16'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: we/idle/rdy1/rdy2=%b cnt1=%0d want 0100 0",
                     {sram_we, idle, req_ready_1, req_ready_2}, wr_count_1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++;
        if (wlog.size() !== 1 || idle !== 1'b1 || wr_count_2 !== 16'd0) begin
            n_fail++;
            $display("FAIL rstmid_after: writes=%0d idle=%b cnt2=%0d want 1 1 0",
                     wlog.size(), idle, wr_count_2);
        end
    endtask

    task automatic test_same_addr_clr();
        do_reset();
        push(1'b1, 12'h0AA, 8'd0, 8'd9, 1'b1, 12'h0BB, 8'd0, 8'd9);
        repeat (4) @(negedge clk);
        n_tests++;
        if (wlog.size() !== 2 || wlog[0].data !== mk_word(12'h0AA, 8'd0) ||
            wlog[1].data !== mk_word(12'h0BB, 8'd0) || wlog[0].addr !== 8'd9 || wlog[1].addr !== 8'd9) begin
            n_fail++;
            $display("FAIL same_addr: writes=%0d want two writes to addr 9, AA then BB", wlog.size());
        end
        n_tests++;
        if (wr_count_1 !== 16'd1 || wr_count_2 !== 16'd1) begin
            n_fail++;
            $display("FAIL same_addr_cnt: cnt1=%0d cnt2=%0d want 1 1", wr_count_1, wr_count_2);
        end
        push(1'b1, 12'h0CC, 8'd0, 8'd9, 1'b0, 12'h0, 8'd0, 8'd0);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        n_tests++;
        if (sram_we !== 1'b1 || wr_count_1 !== 16'd0 || wr_count_2 !== 16'd0) begin
            n_fail++;
            $display("FAIL clr_vs_grant: we=%b cnt1=%0d cnt2=%0d want 1 0 0", sram_we, wr_count_1, wr_count_2);
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_sel_pe = 1'b1; cnt_clr = 1'b0;
        req_valid_1 = 1'b0; req_valid_2 = 1'b0;
        req_tile_1 = '0; req_tile_2 = '0;
        req_od_1 = '0; req_od_2 = '0; req_addr_1 = '0; req_addr_2 = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_scan_hold();
        test_reset_mid();
        test_same_addr_clr();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
